register_write_bank: RTL and testbench
======================================

# register_write_bank

Write side of the processor register file: sixteen W-bit registers loaded through a 4-to-16 write-address decode, presented in parallel to the 16-to-1 read multiplexers. It has three write sources:

- a general write port for ALU and memory results;
- a dedicated link port (R14) for branch-with-link;
- continuous PC tracking on R15.

It sits between the writeback stage and the register read multiplexers of the single-cycle datapath.

## Interface
Parameters:
- W, 32, register width in bits

Ports:
- CLK  input  1  rising-edge clock for all registers
- RESET_N  input  1  asynchronous, active-low reset; clears every register and flag immediately
- WE  input  1  general write enable
- WADDR  input  4  general write register index, 0..15
- WDATA  input  W  general write data
- LINK_WE  input  1  link write enable, always targets R14
- LINK_DATA  input  W  link write data (return address)
- PC_IN  input  W  value R15 loads on every cycle without an explicit R15 write
- Q  output  16*W  register contents; Q[i*W +: W] is register i
- WRITE_ACK  output  1  registered; high for one cycle after any accepted write
- LAST_WADDR  output  4  registered index of the most recent accepted general or link write
- LINK_CONFLICT  output  1  registered; high for one cycle after a dropped link write

## Operation
- Reset (RESET_N low, asynchronous) clears:
  - all 16 registers to 0;
  - WRITE_ACK, LINK_CONFLICT and LAST_WADDR to 0.
- Each rising CLK with RESET_N high, registers R0..R13:
  - R[WADDR] <= WDATA when WE=1 and WADDR=i.
  - Otherwise they hold.
- R14:
  - WE=1 and WADDR=14 loads WDATA.
  - Else LINK_WE=1 loads LINK_DATA.
  - Else R14 holds.
- Link conflict: when WE=1, WADDR=14 and LINK_WE=1 together, the general port wins, the link write is dropped and LINK_CONFLICT pulses.
- R15:
  - WE=1 and WADDR=15 loads WDATA (explicit branch write).
  - Otherwise R15 loads PC_IN every cycle. R15 never holds.
- Simultaneous general and link writes to different registers both take effect in the same edge. A general write to R15 together with LINK_WE is a normal branch-with-link: R15 <= WDATA and R14 <= LINK_DATA.
- WRITE_ACK <= WE | LINK_WE, sampled at the edge.
- LAST_WADDR update:
  - When WE=1, it takes WADDR.
  - When only LINK_WE=1, it takes 14.
  - Otherwise it holds.
- LINK_CONFLICT <= WE & (WADDR==14) & LINK_WE.
- No write-through bypass: Q shows the pre-edge value during the write cycle.
- X/Z on WADDR while WE=0 has no effect. Q, WRITE_ACK, LAST_WADDR and LINK_CONFLICT are all driven from flops.

## Timing
- Write latency is one edge: data presented in cycle n appears on Q after the edge that ends cycle n. Readers see it in cycle n+1.
- WRITE_ACK, LAST_WADDR and LINK_CONFLICT are valid in cycle n+1 for events of cycle n. Each pulse is one cycle wide unless the event repeats.
- Back-to-back writes to the same register each take effect: the last one wins, and WRITE_ACK stays high.
- Reset asserted mid-cycle clears state immediately, and any write pending in that cycle is lost.
- Reset deassertion is synchronised externally. The first edge after deassertion is a normal operating edge, where R15 loads PC_IN.
- There are no combinational paths from inputs to outputs.

## Structure
- The shared processor package holds:
  - localparam REG_LINK = 4'd14 and REG_PC = 4'd15;
  - NUM_REGS = 16.
- Sub-module decoder_4to16 takes (EN, SEL[3:0]) and produces a one-hot 16-bit vector that is zero when EN=0. It is instantiated once for the general port.
- The link and PC paths are per-register next-state logic in the top module. There is one generate loop over 16 registers, with R14 and R15 special-cased.

## Test plan
- Reset: PC_IN=0x100, RESET_N low mid-cycle.
  - Q reads all zero immediately, and WRITE_ACK=0.
  - After release, the next edge gives R15=0x100 and R0..R14=0.
- Decode sweep: WE=1, and for i=0..14 write WADDR=i, WDATA=0xA0+i.
  - After each edge only R[i] changes.
  - WRITE_ACK=1 and LAST_WADDR=i the following cycle.
  - The final Q has R[i]=0xA0+i.
- PC tracking: PC_IN increments by 4 per cycle with no writes; R15 follows one cycle later. Then WE=1, WADDR=15, WDATA=0x2000 gives R15=0x2000, and the next cycle resumes PC_IN.
- Branch-with-link: WE=1, WADDR=15, WDATA=0x400, LINK_WE=1, LINK_DATA=0x108 in one cycle.
  - Next cycle R15=0x400, R14=0x108, LAST_WADDR=15, LINK_CONFLICT=0.
- Conflict: WE=1, WADDR=14, WDATA=0x55, LINK_WE=1, LINK_DATA=0x66.
  - R14=0x55, LINK_CONFLICT=1 for exactly one cycle, LAST_WADDR=14.
- Idle and no-bypass: WE=0 with WADDR toggling randomly leaves R0..R14 unchanged and WRITE_ACK=0. During a write cycle Q still shows the old value.

Source files
------------

// File: rtl/register_write_bank_pkg.sv
// register_write_bank_pkg: register file indices and sizes shared by the write bank.
package register_write_bank_pkg;
    localparam int NUM_REGS = 16;
    localparam logic [3:0] REG_LINK = 4'd14;
    localparam logic [3:0] REG_PC = 4'd15;
endpackage

// File: rtl/register_write_bank_decoder_4to16.sv
// decoder_4to16: one-hot write-address decode, all zero when disabled.
module decoder_4to16
    import register_write_bank_pkg::*;
(
    input  logic                EN,
    input  logic [3:0]          SEL,
    output logic [NUM_REGS-1:0] Y
);
    assign Y = EN ? 16'd1 << SEL : 16'd0;
endmodule

// File: rtl/register_write_bank.sv
// register_write_bank: sixteen W-bit registers with general, link (R14) and PC (R15) write paths.
module register_write_bank
    import register_write_bank_pkg::*;
#(
    parameter int W = 32
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    input  logic                  WE,
    input  logic [3:0]            WADDR,
    input  logic [W-1:0]          WDATA,
    input  logic                  LINK_WE,
    input  logic [W-1:0]          LINK_DATA,
    input  logic [W-1:0]          PC_IN,
    output logic [NUM_REGS*W-1:0] Q,
    output logic                  WRITE_ACK,
    output logic [3:0]            LAST_WADDR,
    output logic                  LINK_CONFLICT
);
    logic [NUM_REGS-1:0] wsel;

    decoder_4to16 u_dec (.EN(WE), .SEL(WADDR), .Y(wsel));

    genvar i;
    for (i = 0; i < NUM_REGS; i++) begin : g_reg
        logic [W-1:0] r;
        logic [W-1:0] nxt;
        // General port always beats link on R14; R15 tracks the PC unless explicitly written.
        if (i == int'(REG_PC)) begin : g_pc
            assign nxt = wsel[i] ? WDATA : PC_IN;
        end else if (i == int'(REG_LINK)) begin : g_link
            assign nxt = wsel[i] ? WDATA : LINK_WE ? LINK_DATA : r;
        end else begin : g_gen
            assign nxt = wsel[i] ? WDATA : r;
        end
        always_ff @(posedge CLK or negedge RESET_N)
            if (!RESET_N) r <= '0;
            else r <= nxt;
        assign Q[i*W +: W] = r;
    end

    always_ff @(posedge CLK or negedge RESET_N)
        if (!RESET_N) begin
            WRITE_ACK     <= 1'b0;
            LAST_WADDR    <= 4'd0;
            LINK_CONFLICT <= 1'b0;
        end else begin
            WRITE_ACK     <= WE | LINK_WE;
            LAST_WADDR    <= WE ? WADDR : LINK_WE ? REG_LINK : LAST_WADDR;
            LINK_CONFLICT <= wsel[REG_LINK] & LINK_WE;
        end
endmodule

// File: tb/tb_register_write_bank.sv
// tb_register_write_bank: directed vectors with hand-computed expectations for the write bank.
module tb_register_write_bank;
    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic        WE = 1'b0;
    logic [3:0]  WADDR = 4'd0;
    logic [31:0] WDATA = '0;
    logic        LINK_WE = 1'b0;
    logic [31:0] LINK_DATA = '0;
    logic [31:0] PC_IN = 32'h100;
    logic [511:0] Q;
    logic        WRITE_ACK;
    logic [3:0]  LAST_WADDR;
    logic        LINK_CONFLICT;

    int vectors = 0;
    int misses = 0;
    logic [31:0] m [16];

    register_write_bank #(.W(32)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .WE(WE), .WADDR(WADDR), .WDATA(WDATA),
        .LINK_WE(LINK_WE), .LINK_DATA(LINK_DATA), .PC_IN(PC_IN), .Q(Q),
        .WRITE_ACK(WRITE_ACK), .LAST_WADDR(LAST_WADDR), .LINK_CONFLICT(LINK_CONFLICT)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] rq(input int i);
        return Q[i*32 +: 32];
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            misses++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_regs(input string tag, input logic [31:0] r15);
        for (int i = 0; i < 15; i++) check($sformatf("%s r%0d", tag, i), rq(i), m[i]);
        check($sformatf("%s r15", tag), rq(15), r15);
    endtask

    task automatic check_flags(input string tag, input logic ack, input logic [3:0] last, input logic conf);
        check({tag, " ack"}, 32'(WRITE_ACK), 32'(ack));
        check({tag, " last"}, 32'(LAST_WADDR), 32'(last));
        check({tag, " conflict"}, 32'(LINK_CONFLICT), 32'(conf));
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) m[i] = '0;
        // reset, then load something so the mid-cycle reset has state to clear
        repeat (2) @(posedge CLK);
        #2 RESET_N = 1'b1;
        WE = 1'b1; WADDR = 4'd3; WDATA = 32'h77;
        step();
        check("pre r3", rq(3), 32'h77);
        check("pre r15", rq(15), 32'h100);
        WDATA = 32'h99;
        #2 RESET_N = 1'b0;
        #1;
        check_regs("async rst", 32'h0);
        check_flags("async rst", 1'b0, 4'd0, 1'b0);
        step();
        check_regs("held rst", 32'h0);
        #2 RESET_N = 1'b1;
        WE = 1'b0;
        step();
        check_regs("post rst", 32'h100);
        check_flags("post rst", 1'b0, 4'd0, 1'b0);

        // decode sweep over R0..R14
        for (int i = 0; i < 15; i++) begin
            WE = 1'b1; WADDR = 4'(i); WDATA = 32'hA0 + 32'(i);
            step();
            m[i] = 32'hA0 + 32'(i);
            check_regs($sformatf("sweep%0d", i), 32'h100);
            check_flags($sformatf("sweep%0d", i), 1'b1, 4'(i), 1'b0);
        end

        // PC tracking
        WE = 1'b0;
        for (int k = 0; k < 4; k++) begin
            PC_IN = 32'h200 + 32'(4 * k);
            step();
            check($sformatf("pc%0d", k), rq(15), 32'h200 + 32'(4 * k));
            check($sformatf("pc%0d ack", k), 32'(WRITE_ACK), 32'h0);
        end
        WE = 1'b1; WADDR = 4'd15; WDATA = 32'h2000; PC_IN = 32'h210;
        step();
        check("branch r15", rq(15), 32'h2000);
        check_flags("branch", 1'b1, 4'd15, 1'b0);
        WE = 1'b0; PC_IN = 32'h214;
        step();
        check("resume r15", rq(15), 32'h214);
        check_flags("resume", 1'b0, 4'd15, 1'b0);

        // branch-with-link
        WE = 1'b1; WADDR = 4'd15; WDATA = 32'h400; LINK_WE = 1'b1; LINK_DATA = 32'h108;
        step();
        m[14] = 32'h108;
        check_regs("bl", 32'h400);
        check_flags("bl", 1'b1, 4'd15, 1'b0);

        // link write alone
        WE = 1'b0; LINK_DATA = 32'h1234;
        step();
        m[14] = 32'h1234;
        check_regs("link", 32'h214);
        check_flags("link", 1'b1, 4'd14, 1'b0);

        // conflict on R14: general port wins
        WE = 1'b1; WADDR = 4'd14; WDATA = 32'h55; LINK_DATA = 32'h66;
        step();
        m[14] = 32'h55;
        check_regs("conf", 32'h214);
        check_flags("conf", 1'b1, 4'd14, 1'b1);
        WE = 1'b0; LINK_WE = 1'b0;
        step();
        check_flags("conf end", 1'b0, 4'd14, 1'b0);

        // idle with random address
        for (int k = 0; k < 6; k++) begin
            WADDR = 4'($urandom_range(0, 15));
            WDATA = $urandom;
            step();
            check_regs($sformatf("idle%0d", k), 32'h214);
            check($sformatf("idle%0d ack", k), 32'(WRITE_ACK), 32'h0);
        end

        // no bypass: Q holds old value during the write cycle
        WE = 1'b1; WADDR = 4'd5; WDATA = 32'hDEAD;
        #1;
        check("nobypass r5", rq(5), 32'hA5);
        step();
        check("write r5", rq(5), 32'hDEAD);

        // back-to-back writes to one register
        WADDR = 4'd2; WDATA = 32'h11;
        step();
        check("b2b1 r2", rq(2), 32'h11);
        check("b2b1 ack", 32'(WRITE_ACK), 32'h1);
        WDATA = 32'h22;
        step();
        check("b2b2 r2", rq(2), 32'h22);
        check("b2b2 ack", 32'(WRITE_ACK), 32'h1);
        WE = 1'b0;
        step();
        check("b2b end ack", 32'(WRITE_ACK), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
        $finish;
    end
endmodule
